// File: rtl/alt_ddrx_wdata_fifo_pa.sv
// Write data FIFO (data + byte enables) with exact beat count; optional partial-BE column via ALT_DDRX_WFIFO_PARTIAL_BE_EN.
// Normal mode: pop -> data next cycle; show-ahead: head registered, push into empty visible next cycle; push dropped when hard full.
module alt_ddrx_wdata_fifo_pa #(
  parameter int WDATA_BEATS_WIDTH = 9,
  parameter int LOCAL_DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH        = 256,
  parameter int ALMOST_FULL_SLACK = 16,
  parameter int SHOWAHEAD         = 0
) (
  input  logic                           ctl_clk,
  input  logic                           ctl_reset,
  input  logic                           write_req_to_wfifo,
  input  logic [LOCAL_DATA_WIDTH-1:0]    wdata_to_wfifo,
  input  logic [LOCAL_DATA_WIDTH/8-1:0]  be_to_wfifo,
  input  logic                           wdata_fifo_read,
  output logic                           wdata_fifo_full,
  output logic                           wdata_fifo_hard_full,
  output logic                           wdata_fifo_empty,
  output logic [LOCAL_DATA_WIDTH-1:0]    wdata_fifo_wdata,
  output logic [LOCAL_DATA_WIDTH/8-1:0]  wdata_fifo_be,
  output logic                           wdata_fifo_valid,
  output logic [WDATA_BEATS_WIDTH-1:0]   beats_in_wfifo,
`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
  output logic                           wdata_fifo_partial_be,
`endif
  output logic                           wdata_fifo_overflow,
  output logic                           wdata_fifo_underflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BE_W = LOCAL_DATA_WIDTH / 8;
`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
  localparam int PBE_W = 1;
`else
  localparam int PBE_W = 0;
`endif
  localparam int WORD_W = LOCAL_DATA_WIDTH + BE_W + PBE_W;
  localparam logic [WDATA_BEATS_WIDTH-1:0] CNT_DEPTH = WDATA_BEATS_WIDTH'(FIFO_DEPTH);
  localparam logic [WDATA_BEATS_WIDTH-1:0] CNT_AFULL = WDATA_BEATS_WIDTH'(FIFO_DEPTH - ALMOST_FULL_SLACK);

  logic [WORD_W-1:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]                rd_addr;
  logic [WDATA_BEATS_WIDTH-1:0] count_q, count_d;
  logic [WORD_W-1:0]            out_q;
  logic [WORD_W-1:0]            wr_word;
  logic                         valid_q, valid_d;
  logic                         ovf_q, ovf_d;
  logic                         unf_q, unf_d;
  logic                         push_ok, pop_ok;
  logic                         load_bypass, load_ram;

  assign wdata_fifo_empty     = (count_q == '0);
  assign wdata_fifo_hard_full = (count_q == CNT_DEPTH);
  assign wdata_fifo_full      = (count_q >= CNT_AFULL);

`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
  assign wr_word = {~(&be_to_wfifo), be_to_wfifo, wdata_to_wfifo};
`else
  assign wr_word = {be_to_wfifo, wdata_to_wfifo};
`endif

  always_comb begin
    push_ok  = write_req_to_wfifo && !wdata_fifo_hard_full;
    pop_ok   = wdata_fifo_read && !wdata_fifo_empty;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + WDATA_BEATS_WIDTH'(1);
      2'b01:   count_d = count_q - WDATA_BEATS_WIDTH'(1);
      default: count_d = count_q;
    endcase
    ovf_d   = ovf_q | (write_req_to_wfifo && wdata_fifo_hard_full);
    unf_d   = unf_q | (wdata_fifo_read && wdata_fifo_empty);
    valid_d = pop_ok;
    // Show-ahead fetches the entry that will be head after this edge; a push
    // landing on that same slot means the FIFO is (or becomes) one deep, so bypass.
    rd_addr     = (SHOWAHEAD != 0) ? rd_ptr_d : rd_ptr_q;
    load_bypass = (SHOWAHEAD != 0) && push_ok && (wr_ptr_q == rd_addr);
    load_ram    = pop_ok && ((SHOWAHEAD == 0) || (count_q != WDATA_BEATS_WIDTH'(1)));
  end

  always_ff @(posedge ctl_clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (load_bypass)   out_q <= wr_word;
      else if (load_ram) out_q <= mem[rd_addr];
    end
  end

  assign wdata_fifo_wdata     = out_q[LOCAL_DATA_WIDTH-1:0];
  assign wdata_fifo_be        = out_q[LOCAL_DATA_WIDTH +: BE_W];
  assign wdata_fifo_valid     = (SHOWAHEAD != 0) ? !wdata_fifo_empty : valid_q;
  assign beats_in_wfifo       = count_q;
  assign wdata_fifo_overflow  = ovf_q;
  assign wdata_fifo_underflow = unf_q;
`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
  assign wdata_fifo_partial_be = out_q[WORD_W-1];
`endif

endmodule

// File: tb/tb_alt_ddrx_wdata_fifo_pa.sv
// Directed bench: one normal-read and one show-ahead instance driven by the same stimulus.
module tb_alt_ddrx_wdata_fifo_pa;

  localparam int CW = 5;

  logic        ctl_clk, ctl_reset;
  logic        wr, rd;
  logic [31:0] wdat;
  logic [3:0]  be;

  logic        full0, hard0, empty0, valid0, ovf0, unf0;
  logic [31:0] wdata0;
  logic [3:0]  be0;
  logic [CW-1:0] beats0;
  logic        full1, hard1, empty1, valid1, ovf1, unf1;
  logic [31:0] wdata1;
  logic [3:0]  be1;
  logic [CW-1:0] beats1;
`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
  logic        pbe0, pbe1;
`endif

  int checks = 0;
  int errors = 0;

  alt_ddrx_wdata_fifo_pa #(
    .WDATA_BEATS_WIDTH(CW), .LOCAL_DATA_WIDTH(32), .FIFO_DEPTH(16),
    .ALMOST_FULL_SLACK(4), .SHOWAHEAD(0)
  ) u_dut0 (
    .ctl_clk(ctl_clk), .ctl_reset(ctl_reset),
    .write_req_to_wfifo(wr), .wdata_to_wfifo(wdat), .be_to_wfifo(be),
    .wdata_fifo_read(rd),
    .wdata_fifo_full(full0), .wdata_fifo_hard_full(hard0), .wdata_fifo_empty(empty0),
    .wdata_fifo_wdata(wdata0), .wdata_fifo_be(be0), .wdata_fifo_valid(valid0),
    .beats_in_wfifo(beats0),
`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
    .wdata_fifo_partial_be(pbe0),
`endif
    .wdata_fifo_overflow(ovf0), .wdata_fifo_underflow(unf0)
  );

  alt_ddrx_wdata_fifo_pa #(
    .WDATA_BEATS_WIDTH(CW), .LOCAL_DATA_WIDTH(32), .FIFO_DEPTH(16),
    .ALMOST_FULL_SLACK(4), .SHOWAHEAD(1)
  ) u_dut1 (
    .ctl_clk(ctl_clk), .ctl_reset(ctl_reset),
    .write_req_to_wfifo(wr), .wdata_to_wfifo(wdat), .be_to_wfifo(be),
    .wdata_fifo_read(rd),
    .wdata_fifo_full(full1), .wdata_fifo_hard_full(hard1), .wdata_fifo_empty(empty1),
    .wdata_fifo_wdata(wdata1), .wdata_fifo_be(be1), .wdata_fifo_valid(valid1),
    .beats_in_wfifo(beats1),
`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
    .wdata_fifo_partial_be(pbe1),
`endif
    .wdata_fifo_overflow(ovf1), .wdata_fifo_underflow(unf1)
  );

  initial begin
    ctl_clk = 1'b0;
    forever #5 ctl_clk = ~ctl_clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input logic w, input logic r, input logic [31:0] d, input logic [3:0] b);
    wr = w; rd = r; wdat = d; be = b;
    @(posedge ctl_clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    ctl_reset = 1'b1;
    wr = 1'b0; rd = 1'b0; wdat = '0; be = '0;
    #12;
    check_eq("rst_count", beats0, 0);
    check_eq("rst_empty", empty0, 1);
    check_eq("rst_full", full0, 0);
    check_eq("rst_hard", hard0, 0);
    check_eq("rst_valid0", valid0, 0);
    check_eq("rst_valid1", valid1, 0);
    check_eq("rst_wdata0", wdata0, 0);
    check_eq("rst_ovf", ovf0, 0);
    check_eq("rst_unf", unf0, 0);
    @(posedge ctl_clk); #1;
    ctl_reset = 1'b0;

    // Fill to almost-full, then hard-full
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 32'(i), 4'hF);
      if (i == 10) begin
        check_eq("afull_11_full", full0, 0);
        check_eq("afull_11_count", beats0, 11);
      end
    end
    check_eq("afull_count", beats0, 12);
    check_eq("afull_full", full0, 1);
    check_eq("afull_hard", hard0, 0);
    for (int i = 12; i < 16; i++) tick(1'b1, 1'b0, 32'(i), 4'hF);
    check_eq("hfull_count", beats0, 16);
    check_eq("hfull_hard", hard0, 1);
    check_eq("hfull_hard_sa", hard1, 1);
    check_eq("hfull_ovf", ovf0, 0);

    tick(1'b1, 1'b0, 32'h99, 4'hF);
    check_eq("ovf_set", ovf0, 1);
    check_eq("ovf_set_sa", ovf1, 1);
    check_eq("ovf_count", beats0, 16);
    check_eq("pre_pop_valid0", valid0, 0);
    check_eq("pre_pop_valid1", valid1, 1);

    for (int i = 0; i < 16; i++) begin
      check_eq("sa_head", wdata1, 32'(i));
      tick(1'b0, 1'b1, 32'h0, 4'h0);
      check_eq("pop_valid", valid0, 1);
      check_eq("pop_data", wdata0, 32'(i));
      check_eq("pop_be", be0, 4'hF);
    end
    tick(1'b0, 1'b0, 32'h0, 4'h0);
    check_eq("drain_valid0", valid0, 0);
    check_eq("drain_hold", wdata0, 32'hF);
    check_eq("drain_empty", empty0, 1);
    check_eq("drain_count", beats0, 0);
    check_eq("drain_valid1", valid1, 0);
    check_eq("drain_unf", unf0, 0);

    // Push+pop on empty FIFO
    tick(1'b1, 1'b1, 32'h55, 4'h3);
    check_eq("pp_count", beats0, 1);
    check_eq("pp_unf", unf0, 1);
    check_eq("pp_valid0", valid0, 0);
    check_eq("pp_valid1", valid1, 1);
    check_eq("pp_data1", wdata1, 32'h55);
    check_eq("pp_be1", be1, 4'h3);
    tick(1'b0, 1'b1, 32'h0, 4'h0);
    check_eq("pp_pop_data", wdata0, 32'h55);
    check_eq("pp_pop_be", be0, 4'h3);
    check_eq("pp_pop_count", beats0, 0);

    // Show-ahead bypass into empty
    tick(1'b1, 1'b0, 32'hA5A5A5A5, 4'hF);
    check_eq("sa_byp_valid", valid1, 1);
    check_eq("sa_byp_data", wdata1, 32'hA5A5A5A5);
    tick(1'b0, 1'b1, 32'h0, 4'h0);
    check_eq("sa_pop_valid", valid1, 0);
    check_eq("sa_pop_empty", empty1, 1);
    check_eq("sa_pop_data0", wdata0, 32'hA5A5A5A5);

    // Steady state at depth 8 with pointer wrap
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 32'h100 + 32'(k), 4'hF);
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b1, 32'h108 + 32'(k), 4'hF);
      check_eq("ss_count", beats0, 8);
      check_eq("ss_data0", wdata0, 32'h100 + 32'(k));
      check_eq("ss_valid0", valid0, 1);
      check_eq("ss_data1", wdata1, 32'h101 + 32'(k));
    end

    // Asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 32'h0, 4'h0);
    check_eq("mid_count", beats0, 5);
    #2;
    ctl_reset = 1'b1;
    #1;
    check_eq("arst_count", beats0, 0);
    check_eq("arst_empty", empty0, 1);
    check_eq("arst_valid0", valid0, 0);
    check_eq("arst_valid1", valid1, 0);
    check_eq("arst_data0", wdata0, 0);
    check_eq("arst_data1", wdata1, 0);
    check_eq("arst_ovf", ovf0, 0);
    check_eq("arst_unf", unf0, 0);
`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
    check_eq("arst_pbe", pbe0, 0);
`endif
    @(posedge ctl_clk); #1;
    ctl_reset = 1'b0;
    tick(1'b1, 1'b0, 32'h1, 4'hF);
    check_eq("post_rst_head", wdata1, 32'h1);
    check_eq("post_rst_count", beats0, 1);
    tick(1'b0, 1'b1, 32'h0, 4'h0);
    check_eq("post_rst_data", wdata0, 32'h1);
    check_eq("post_rst_valid", valid0, 1);

`ifdef ALT_DDRX_WFIFO_PARTIAL_BE_EN
    tick(1'b1, 1'b0, 32'h2, 4'hF);
    tick(1'b1, 1'b0, 32'h3, 4'h7);
    check_eq("pbe_head1", pbe1, 0);
    tick(1'b0, 1'b1, 32'h0, 4'h0);
    check_eq("pbe_first", pbe0, 0);
    check_eq("pbe_head2", pbe1, 1);
    tick(1'b0, 1'b1, 32'h0, 4'h0);
    check_eq("pbe_second", pbe0, 1);
    check_eq("pbe_be", be0, 4'h7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alt_ddrx_wdata_fifo_pa.md
Name: alt_ddrx_wdata_fifo_pa

Overview:
Parametrised write data FIFO for the DDRx controller, successor to the fixed 256-deep write data FIFO. It stores local write data plus byte enables on an inferred RAM and reports an exact beat count to the command state machine. Depth, almost-full slack and read mode (normal or show-ahead) are configurable, with explicit valid, empty and hard-full flags and sticky overflow/underflow error flags. It sits between the local write-data interface and the write datapath.

Parameters:
WDATA_BEATS_WIDTH, 9, width of beats_in_wfifo; must be >= log2(FIFO_DEPTH)+1.
LOCAL_DATA_WIDTH, 32, data width in bits; multiple of 8.
FIFO_DEPTH, 256, number of entries; power of 2, minimum 4.
ALMOST_FULL_SLACK, 16, free entries remaining when wdata_fifo_full asserts; 1 to FIFO_DEPTH-1.
SHOWAHEAD, 0, 0 = normal read with 1-cycle latency; 1 = head entry presented before it is read.

Ports:
ctl_clk  in  1  controller clock
ctl_reset  in  1  asynchronous active-high reset
write_req_to_wfifo  in  1  push one beat
wdata_to_wfifo  in  LOCAL_DATA_WIDTH  write data
be_to_wfifo  in  LOCAL_DATA_WIDTH/8  byte enables, one per byte
wdata_fifo_read  in  1  pop one beat
wdata_fifo_full  out  1  almost-full backpressure
wdata_fifo_hard_full  out  1  FIFO_DEPTH entries stored
wdata_fifo_empty  out  1  zero entries stored
wdata_fifo_wdata  out  LOCAL_DATA_WIDTH  read data
wdata_fifo_be  out  LOCAL_DATA_WIDTH/8  read byte enables
wdata_fifo_valid  out  1  wdata/be hold a valid beat
beats_in_wfifo  out  WDATA_BEATS_WIDTH  entries currently stored
wdata_fifo_overflow  out  1  sticky: push attempted while hard full
wdata_fifo_underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (asynchronous, ctl_reset=1): pointers=0, beats_in_wfifo=0, empty=1, full=0, hard_full=0, valid=0, wdata/be=0, overflow=0, underflow=0. RAM contents undefined. Reset mid-burst discards all entries; the first push after reset is stored at entry 0.
- Push accepted iff write_req_to_wfifo=1 and hard_full=0. A push while hard full is dropped; overflow sets on the next edge and stays set until reset.
- Pop accepted iff wdata_fifo_read=1 and empty=0, judged on the registered state before the edge. A pop while empty is ignored; underflow sets and stays set until reset. A push and pop in the same cycle on an empty FIFO: the push is accepted, the pop is rejected and underflow sets.
- beats_in_wfifo: accepted push only gives +1; accepted pop only gives -1; both accepted leaves it unchanged. It counts accepted operations only and never wraps.
- Flags are decoded from the registered count: empty = (count==0); hard_full = (count==FIFO_DEPTH); full = (count >= FIFO_DEPTH-ALMOST_FULL_SLACK).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0.
- SHOWAHEAD=0: an accepted pop in cycle C gives data/be on outputs and valid=1 in cycle C+1. Valid=0 in any cycle not following an accepted pop. Data/be hold their last value while valid=0.
- SHOWAHEAD=1: outputs always show the head entry; valid = !empty. A push into an empty FIFO in cycle C makes data visible with valid=1 in cycle C+1 (bypass path). An accepted pop in cycle C presents the next entry in cycle C+1. Back-to-back pops sustain 1 beat per cycle.
- Entries are read out in strict FIFO order; data and be stay aligned.

Optional Feature:
Macro ALT_DDRX_WFIFO_PARTIAL_BE_EN.
- Defined: extra output wdata_fifo_partial_be (1 bit). It is computed at push time as !(&be_to_wfifo) and stored as an extra RAM column. It is aligned with wdata_fifo_wdata and valid in both modes; reset value 0. It marks beats that need read-modify-write.
- Undefined: the port and the RAM column are absent.

Test Plan:
- FIFO_DEPTH=16, SLACK=4, SHOWAHEAD=0: push 12 beats 0x0..0xB -> full=1 with count=12; push 4 more -> hard_full=1 with count=16.
- Continue from 16 stored: push once more -> overflow=1, count stays 16; pop 16 -> data 0x0..0xF in order, each one cycle after its pop; empty=1.
- Empty FIFO: push and pop in the same cycle -> count=1, underflow=1, valid=0 in the next cycle.
- SHOWAHEAD=1: push 0xA5A5A5A5 in cycle C -> valid=1 with data 0xA5A5A5A5 in C+1; pop -> valid=0 and empty=1 in the next cycle.
- Steady push+pop every cycle for 40 cycles with count starting at 8 -> count stays 8, pointers wrap, data is the expected sequence.
- Assert ctl_reset mid-stream with count=5 -> all outputs at reset values immediately; after release, push 0x1 then pop -> returns 0x1. With the macro defined, push be=0xF then be=0x7 -> partial_be reads 0 then 1.
